// File: rtl/scr1_tcm_portb_arbiter.sv
// Round-robin arbiter sharing TCM port B between the LSU (port 0) and an external master (port 1).
// Issues one access per cycle, aligns write lanes, and extracts read data one cycle after acceptance.
module scr1_tcm_portb_arbiter #(
   parameter int SCR1_WIDTH  = 32,
   parameter int SCR1_SIZE   = 32'h00010000,
   parameter int SCR1_NBYTES = SCR1_WIDTH / 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            req0,
   output logic                            ack0,
   input  logic                            cmd0,
   input  logic [1:0]                      width0,
   input  logic [31:0]                     addr0,
   input  logic [SCR1_WIDTH-1:0]           wdata0,
   output logic [SCR1_WIDTH-1:0]           rdata0,
   output logic [1:0]                      resp0,
   input  logic                            req1,
   output logic                            ack1,
   input  logic                            cmd1,
   input  logic [1:0]                      width1,
   input  logic [31:0]                     addr1,
   input  logic [SCR1_WIDTH-1:0]           wdata1,
   output logic [SCR1_WIDTH-1:0]           rdata1,
   output logic [1:0]                      resp1,
   output logic                            renb,
   output logic                            wenb,
   output logic [SCR1_NBYTES-1:0]          webb,
   output logic [$clog2(SCR1_SIZE)-3:0]    addrb,
   output logic [SCR1_WIDTH-1:0]           datab,
   input  logic [SCR1_WIDTH-1:0]           qb
);

   localparam int AB = $clog2(SCR1_SIZE);

   logic                   last_grant_q;
   logic                   last_grant_d;
   logic [1:0]             gnt;
   logic                   s_cmd;
   logic [1:0]             s_width;
   logic [AB-1:0]          s_addr;
   logic [SCR1_WIDTH-1:0]  s_wdata;
   logic                   s_err;
   logic                   s_ok;
   logic [SCR1_NBYTES-1:0] s_be;
   logic [SCR1_WIDTH-1:0]  s_data;
   logic                   unused_addr_hi;

   assign unused_addr_hi = ^{addr0[31:AB], addr1[31:AB]};

   // Grant is forced low during reset so every memory-side output is quiet.
   always_comb begin
      gnt = 2'b00;
      if (!rst) begin
         if (req0 && req1) begin
            gnt = last_grant_q ? 2'b01 : 2'b10;
         end else begin
            gnt = {req1, req0};
         end
      end
   end

   assign last_grant_d = gnt[1] ? 1'b1 : (gnt[0] ? 1'b0 : last_grant_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_grant_q <= 1'b1;
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

   assign ack0    = gnt[0];
   assign ack1    = gnt[1];
   assign s_cmd   = gnt[1] ? cmd1   : cmd0;
   assign s_width = gnt[1] ? width1 : width0;
   assign s_addr  = gnt[1] ? addr1[AB-1:0] : addr0[AB-1:0];
   assign s_wdata = gnt[1] ? wdata1 : wdata0;

   always_comb begin
      case (s_width)
         2'b00:   s_err = 1'b0;
         2'b01:   s_err = s_addr[0];
         2'b10:   s_err = |s_addr[1:0];
         default: s_err = 1'b1;
      endcase
   end

   always_comb begin
      s_be   = '1;
      s_data = s_wdata;
      case (s_width)
         2'b00: begin
            s_be   = SCR1_NBYTES'(1) << s_addr[1:0];
            s_data = {4{s_wdata[7:0]}};
         end
         2'b01: begin
            s_be   = SCR1_NBYTES'(3) << s_addr[1:0];
            s_data = {2{s_wdata[15:0]}};
         end
         default: begin
            s_be   = '1;
            s_data = s_wdata;
         end
      endcase
   end

   assign s_ok  = (|gnt) && !s_err;
   assign renb  = s_ok && !s_cmd;
   assign wenb  = s_ok && s_cmd;
   assign webb  = wenb ? s_be : '0;
   assign addrb = (|gnt) ? s_addr[AB-1:2] : '0;
   assign datab = (|gnt) ? s_data : '0;

   for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic                  vld_q, vld_d;
      logic                  err_q, err_d;
      logic                  cmd_q, cmd_d;
      logic [1:0]            off_q, off_d;
      logic [1:0]            width_q, width_d;
      logic [SCR1_WIDTH-1:0] shifted;
      logic [SCR1_WIDTH-1:0] rdata;
      logic [1:0]            resp;

      always_comb begin
         vld_d   = gnt[gi];
         err_d   = err_q;
         cmd_d   = cmd_q;
         off_d   = off_q;
         width_d = width_q;
         if (gnt[gi]) begin
            err_d   = s_err;
            cmd_d   = s_cmd;
            off_d   = s_addr[1:0];
            width_d = s_width;
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            cmd_q   <= 1'b0;
            off_q   <= 2'b00;
            width_q <= 2'b00;
         end else begin
            vld_q   <= vld_d;
            err_q   <= err_d;
            cmd_q   <= cmd_d;
            off_q   <= off_d;
            width_q <= width_d;
         end
      end

      assign shifted = qb >> {off_q, 3'b000};

      always_comb begin
         rdata = '0;
         if (vld_q && !err_q && !cmd_q) begin
            case (width_q)
               2'b00:   rdata = {{(SCR1_WIDTH-8){1'b0}}, shifted[7:0]};
               2'b01:   rdata = {{(SCR1_WIDTH-16){1'b0}}, shifted[15:0]};
               default: rdata = shifted;
            endcase
         end
      end

      assign resp = vld_q ? (err_q ? 2'b10 : 2'b01) : 2'b00;
   end

   assign resp0  = g_port[0].resp;
   assign rdata0 = g_port[0].rdata;
   assign resp1  = g_port[1].resp;
   assign rdata1 = g_port[1].rdata;

endmodule
